// File: rtl/ws_array_controller_pkg.sv
// Shared constants for the weight-stationary array controller: FSM state
// encodings (3-bit binary) and the weight-settle length.
package ws_array_controller_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] WLOAD   = 3'd2;
  localparam logic [2:0] WSETTLE = 3'd3;
  localparam logic [2:0] STREAM  = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  // Cycles the cell_sc_en chain needs before the weights are stable.
  localparam int SETTLE_CYC = 2;

endpackage

// File: rtl/ws_array_controller_counter.sv
// ws_ctrl_counter: up-counter with synchronous clear, load and enable, plus a
// terminal-value compare. Used for every phase/length count in the controller.
module ws_ctrl_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/ws_array_controller.sv
// ws_array_controller: per-tile sequencer for a ROWS x COLS weight-stationary
// PE array (clear, weight preload, stream, drain, done).
// Optional perf counters are built when WS_CTRL_PERF_EN is defined.
module ws_array_controller
  import ws_array_controller_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int STAGE = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] k_len,
  input  logic             abort,
  input  logic             wei_valid,
  output logic             wei_rd,
  input  logic             act_valid,
  output logic             act_rd,
  output logic             reg_clear,
  output logic             cell_sc_en,
  output logic             cell_en,
  output logic             pipeline_en,
  output logic             cscan_en,
  output logic             out_valid,
  output logic             busy,
  output logic             done
`ifdef WS_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
`endif
);

  localparam int WW    = $clog2(ROWS + 1);
  localparam int SW    = CNT_W + 1;
  localparam int PMAX  = (COLS > SETTLE_CYC) ? COLS : SETTLE_CYC;
  localparam int PW    = $clog2(PMAX + 1);
  localparam int FIXED = ROWS + COLS + STAGE - 2;

  logic [2:0]       state, state_next;
  logic             abort_pend;
  logic [CNT_W-1:0] k_q;
  logic             start_go;

  logic [WW-1:0]    wcnt;
  logic [CNT_W-1:0] acnt;
  logic [SW-1:0]    scnt, s_last;
  logic [PW-1:0]    pcnt, p_last;
  logic             w_term, a_term, s_term, p_term;
  logic             a_pending, phase_run, phase_clr, cnt_clr;

  assign start_go  = (state == IDLE) && start && !abort;
  assign a_pending = !a_term;
  assign phase_run = (state == WSETTLE) || (state == DRAIN);
  assign phase_clr = abort || !phase_run || p_term;
  assign cnt_clr   = abort || (state == CLEAR);
  assign s_last    = {1'b0, k_q} + SW'(FIXED);
  assign p_last    = (state == WSETTLE) ? PW'(SETTLE_CYC - 1) : PW'(COLS - 1);

  // Handshake strobes are combinational so a buffer pop costs no bubble.
  assign wei_rd      = (state == WLOAD) && wei_valid;
  assign act_rd      = (state == STREAM) && a_pending && act_valid;
  assign pipeline_en = (state == STREAM) && (a_pending ? act_valid : 1'b1);

  ws_ctrl_counter #(.W(WW)) u_wcnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .load(1'b0), .load_val('0),
    .en(wei_rd), .term(WW'(ROWS - 1)), .count(wcnt), .at_term(w_term)
  );

  ws_ctrl_counter #(.W(CNT_W)) u_acnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .load(1'b0), .load_val('0),
    .en(act_rd), .term(k_q), .count(acnt), .at_term(a_term)
  );

  ws_ctrl_counter #(.W(SW)) u_scnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .load(1'b0), .load_val('0),
    .en(pipeline_en), .term(s_last), .count(scnt), .at_term(s_term)
  );

  // Shared between the settle wait and the drain scan; never both active.
  ws_ctrl_counter #(.W(PW)) u_pcnt (
    .clk(clk), .rst_n(rst_n), .clr(phase_clr), .load(1'b0), .load_val('0),
    .en(phase_run), .term(p_last), .count(pcnt), .at_term(p_term)
  );

  // NOTE: state_next gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (start_go) state_next = CLEAR;
    end else if (abort) begin
      state_next = CLEAR;
    end else begin
      case (state)
        CLEAR:   state_next = abort_pend ? IDLE : WLOAD;
        WLOAD:   if (wei_rd && w_term) state_next = WSETTLE;
        WSETTLE: if (p_term) state_next = (k_q == '0) ? DONE : STREAM;
        STREAM:  if (pipeline_en && s_term) state_next = DRAIN;
        DRAIN:   if (p_term) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      abort_pend <= 1'b0;
      k_q        <= '0;
    end else begin
      state <= state_next;
      if (start_go) k_q <= k_len;
      if (abort && state != IDLE) abort_pend <= 1'b1;
      else if (state == CLEAR)    abort_pend <= 1'b0;
    end
  end

  // Registered outputs decode the next state so they line up with the state
  // they belong to. cell_sc_en trails wei_rd by one cycle, matching the
  // weight row arriving from the buffer after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_clear  <= 1'b0;
      cell_sc_en <= 1'b0;
      cell_en    <= 1'b0;
      cscan_en   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      reg_clear  <= (state_next == CLEAR);
      cell_sc_en <= wei_rd && !abort;
      cell_en    <= (state_next == STREAM);
      cscan_en   <= (state_next == DRAIN);
      out_valid  <= pipeline_en && !abort && (scnt >= SW'(ROWS + STAGE));
      busy       <= (state_next != IDLE);
      done       <= (state_next == DONE);
    end
  end

`ifdef WS_CTRL_PERF_EN
  logic stall;
  assign stall = (state == STREAM) && a_pending && !act_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_go) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (state != IDLE && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (stall && perf_stalls != '1)         perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  // Perf counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ws_array_controller.sv
// Self-checking bench for ws_array_controller: a per-cycle schedule of the
// expected control outputs is derived from the tile rules and the drawn valids.
module tb_ws_array_controller;

  localparam int R     = 4;
  localparam int C     = 4;
  localparam int S     = 0;
  localparam int CW    = 16;
  localparam int MAXC  = 1024;

  // Bit positions inside the packed output vector.
  localparam int B_RC = 9, B_WRD = 8, B_SC = 7, B_CE = 6, B_PE = 5;
  localparam int B_ARD = 4, B_OV = 3, B_CS = 2, B_BUSY = 1, B_DONE = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] k_len = '0;
  logic          abort = 1'b0;
  logic          wei_valid = 1'b0;
  logic          act_valid = 1'b0;
  logic          wei_rd, act_rd, reg_clear, cell_sc_en, cell_en;
  logic          pipeline_en, cscan_en, out_valid, busy, done;
`ifdef WS_CTRL_PERF_EN
  logic [31:0]   perf_cycles, perf_stalls;
`endif

  int checks = 0;
  int errors = 0;

  logic       w_pat [0:MAXC-1];
  logic       v_pat [0:MAXC-1];
  logic [9:0] exp_v [0:MAXC-1];
  int exp_busy, exp_stalls;
  int obs_pe, obs_ov, obs_cs, obs_ce, obs_ard, obs_wrd;

  ws_array_controller #(.ROWS(R), .COLS(C), .STAGE(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
    .wei_valid(wei_valid), .wei_rd(wei_rd), .act_valid(act_valid), .act_rd(act_rd),
    .reg_clear(reg_clear), .cell_sc_en(cell_sc_en), .cell_en(cell_en),
    .pipeline_en(pipeline_en), .cscan_en(cscan_en), .out_valid(out_valid),
    .busy(busy), .done(done)
`ifdef WS_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {reg_clear, wei_rd, cell_sc_en, cell_en, pipeline_en,
            act_rd, out_valid, cscan_en, busy, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern(input int pct);
    for (int i = 0; i < MAXC; i++) begin
      w_pat[i] = ($urandom_range(99) < pct);
      v_pat[i] = ($urandom_range(99) < pct);
    end
  endtask

  // Expected schedule: cycle 0 is the CLEAR cycle following the start edge.
  // Returns the number of cycles to observe.
  task automatic build_model(input int k, input int abort_at, output int n);
    int c, got, adv, cons, t_len, done_idx;
    for (int i = 0; i < MAXC; i++) exp_v[i] = '0;
    exp_stalls = 0;
    exp_v[0][B_RC]   = 1'b1;
    exp_v[0][B_BUSY] = 1'b1;
    c = 1;
    got = 0;
    while (got < R && c < MAXC - 64) begin
      exp_v[c][B_BUSY] = 1'b1;
      if (w_pat[c]) begin
        exp_v[c][B_WRD]  = 1'b1;
        exp_v[c+1][B_SC] = 1'b1;
        got++;
      end
      c++;
    end
    for (int i = 0; i < 2; i++) begin
      exp_v[c][B_BUSY] = 1'b1;
      c++;
    end
    if (k > 0) begin
      t_len = k + R + C + S - 1;
      adv = 0;
      cons = 0;
      while (adv < t_len && c < MAXC - 16) begin
        exp_v[c][B_BUSY] = 1'b1;
        exp_v[c][B_CE]   = 1'b1;
        if (cons < k && !v_pat[c]) begin
          exp_stalls++;
        end else begin
          if (cons < k) begin
            exp_v[c][B_ARD] = 1'b1;
            cons++;
          end
          exp_v[c][B_PE] = 1'b1;
          if (adv >= R + S) exp_v[c+1][B_OV] = 1'b1;
          adv++;
        end
        c++;
      end
      for (int i = 0; i < C; i++) begin
        exp_v[c][B_BUSY] = 1'b1;
        exp_v[c][B_CS]   = 1'b1;
        c++;
      end
    end
    exp_v[c][B_BUSY] = 1'b1;
    exp_v[c][B_DONE] = 1'b1;
    done_idx = c;
    exp_busy = done_idx + 1;
    n = done_idx + 2;
    if (abort_at >= 0 && abort_at < done_idx) begin
      for (int i = abort_at + 1; i < MAXC; i++) exp_v[i] = '0;
      exp_v[abort_at+1][B_RC]   = 1'b1;
      exp_v[abort_at+1][B_BUSY] = 1'b1;
      n = abort_at + 3;
    end
  endtask

  task automatic run_tile(input int id, input int k, input int abort_at);
    int n;
    logic [9:0] o;
    build_model(k, abort_at, n);
    obs_pe = 0; obs_ov = 0; obs_cs = 0; obs_ce = 0; obs_ard = 0; obs_wrd = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = CW'(k);
    wei_valid = 1'b0;
    act_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c == abort_at);
      wei_valid = w_pat[c];
      act_valid = v_pat[c];
      #1;
      o = outs();
      obs_pe  += int'(o[B_PE]);
      obs_ov  += int'(o[B_OV]);
      obs_cs  += int'(o[B_CS]);
      obs_ce  += int'(o[B_CE]);
      obs_ard += int'(o[B_ARD]);
      obs_wrd += int'(o[B_WRD]);
      check($sformatf("tile%0d_k%0d_cyc%0d", id, k, c), 32'(o), 32'(exp_v[c]));
    end
    abort = 1'b0;
`ifdef WS_CTRL_PERF_EN
    if (abort_at < 0) begin
      check($sformatf("tile%0d_perf_cycles", id), perf_cycles, 32'(exp_busy));
      check($sformatf("tile%0d_perf_stalls", id), perf_stalls, 32'(exp_stalls));
    end
`endif
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1 check("reset_async_outs", 32'(outs()), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("reset_idle_outs", 32'(outs()), 32'h0);

    // Scenario 1: k=3, valids tied high
    for (int i = 0; i < MAXC; i++) begin w_pat[i] = 1'b1; v_pat[i] = 1'b1; end
    run_tile(1, 3, -1);
    check("s1_pipeline_en_cycles", 32'(obs_pe), 32'd10);
    check("s1_out_valid_count", 32'(obs_ov), 32'd6);
    check("s1_cscan_en_cycles", 32'(obs_cs), 32'd4);
    check("s1_wei_rd_count", 32'(obs_wrd), 32'd4);

    // Scenario 2: act_valid low for STREAM cycles 2-4 (stream starts at cycle 7)
    for (int i = 8; i <= 10; i++) v_pat[i] = 1'b0;
    run_tile(2, 3, -1);
    check("s2_stream_cycles", 32'(obs_ce), 32'd13);
    check("s2_pipeline_en_cycles", 32'(obs_pe), 32'd10);
    check("s2_out_valid_count", 32'(obs_ov), 32'd6);
`ifdef WS_CTRL_PERF_EN
    check("s2_perf_stalls_const", perf_stalls, 32'd3);
    check("s2_perf_cycles_const", perf_cycles, 32'd25);
`endif

    // Scenario 3: k=0 skips STREAM and DRAIN
    fill_pattern(60);
    run_tile(3, 0, -1);
    check("s3_act_rd_count", 32'(obs_ard), 32'd0);
    check("s3_pipeline_en_count", 32'(obs_pe), 32'd0);
    check("s3_cscan_en_count", 32'(obs_cs), 32'd0);

    // Scenario 4: abort mid-STREAM (valids high, stream starts at cycle 7)
    for (int i = 0; i < MAXC; i++) begin w_pat[i] = 1'b1; v_pat[i] = 1'b1; end
    run_tile(4, 5, 10);
    fill_pattern(70);
    run_tile(5, 4, -1);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    k_len = CW'(2);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1 check("idle_abort_beats_start", 32'(outs()), 32'h0);

    // Scenario 5: async reset while stalled in WLOAD
    @(negedge clk);
    start = 1'b1;
    k_len = CW'(2);
    wei_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    wei_valid = 1'b1;
    #1 check("s5_wload_wei_rd", 32'(wei_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("s5_async_reset_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    wei_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("s5_idle_after_release", 32'(outs()), 32'h0);

    // Randomized tiles
    for (int t = 0; t < 6; t++) begin
      fill_pattern(45 + 10 * (t % 4));
      run_tile(10 + t, int'($urandom_range(12)), -1);
    end
    fill_pattern(60);
    run_tile(20, 7, int'($urandom_range(3, 14)));
    fill_pattern(60);
    run_tile(21, 6, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
